pkt_concentrator_n: RTL and testbench

Parametrised successor to the port byte-to-word concentrator. It packs the 8-bit code/data srdy/drdy stream from the packet parser into LANES-byte words for the rx packet FIFO, and drives commit/abort into that FIFO. Unlike the fixed-width concentrator, it adds these behaviours:
- runt and giant frame filtering
- abort on CRC-bad end-of-packet
- truncation of a packet interrupted by a new start-of-packet
- per-packet length and drop-event pulses
It sits between the parser and the rx FIFO in the port datapath.

---
 rtl/pkt_concentrator_n.sv | 218 +++++++++++++++++++++
 tb/tb_pkt_concentrator_n.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_concentrator_n.sv
// Packs the parser's code/data byte stream into LANES-byte words for the rx packet FIFO.
// Filters runt, giant, CRC-bad and truncated frames by marking their final word with p_abort.
//
// state   | meaning
// S_IDLE  | between packets; waits for SOP, discards data/EOP bytes
// S_PKT   | collecting packet bytes into the accumulator
// S_DRAIN | giant frame already aborted; discarding bytes up to EOP
module pkt_concentrator_n #(
    parameter int LANES   = 8,
    parameter int LSZ     = 3,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_SZ  = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c_srdy,
    output logic               c_drdy,
    input  logic [1:0]         c_code,
    input  logic [7:0]         c_data,
    output logic               p_srdy,
    input  logic               p_drdy,
    output logic [1:0]         p_code,
    output logic [LSZ-1:0]     p_cnt,
    output logic [LANES*8-1:0] p_data,
    output logic               p_commit,
    output logic               p_abort,
    output logic [LEN_SZ-1:0]  pkt_len,
    output logic               drop_runt,
    output logic               drop_giant,
    output logic               drop_crc
);

    localparam logic [1:0] C_SOP     = 2'b00;
    localparam logic [1:0] C_DATA    = 2'b01;
    localparam logic [1:0] C_EOP_BAD = 2'b11;

    localparam logic [1:0] W_FIRST  = 2'b00;
    localparam logic [1:0] W_MID    = 2'b01;
    localparam logic [1:0] W_LAST   = 2'b10;
    localparam logic [1:0] W_SINGLE = 2'b11;

    localparam logic [LEN_SZ-1:0] GIANT_LEN = LEN_SZ'(MAX_LEN + 1);
    localparam logic [LEN_SZ-1:0] MIN_L     = LEN_SZ'(MIN_LEN);
    localparam logic [LSZ-1:0]    LANE_LAST = LSZ'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_DRAIN} state_t;

    state_t               state, state_n;
    logic [LSZ-1:0]       lane, lane_n;
    logic [LEN_SZ-1:0]    len, len_n, len_inc;
    logic                 first, first_n;
    logic [LANES*8-1:0]   acc, acc_n, merged;
    logic                 out_free;

    logic                 load;
    logic [1:0]           ld_code;
    logic [LSZ-1:0]       ld_cnt;
    logic [LANES*8-1:0]   ld_data;
    logic                 ld_commit, ld_abort, ld_len;
    logic                 ld_runt, ld_giant, ld_crc;

    assign out_free = ~p_srdy | p_drdy;
    assign len_inc  = (len == GIANT_LEN) ? len : len + LEN_SZ'(1);

    // Accumulator with the incoming byte dropped into the current lane; this is the word
    // that leaves when the byte completes it.
    always_comb begin
        merged = acc;
        merged[{lane, 3'b000} +: 8] = c_data;
    end

    always_comb begin
        state_n   = state;
        lane_n    = lane;
        len_n     = len;
        first_n   = first;
        acc_n     = acc;
        load      = 1'b0;
        ld_code   = W_LAST;
        ld_cnt    = lane;
        ld_data   = merged;
        ld_commit = 1'b0;
        ld_abort  = 1'b0;
        ld_len    = 1'b0;
        ld_runt   = 1'b0;
        ld_giant  = 1'b0;
        ld_crc    = 1'b0;
        c_drdy    = (state == S_DRAIN) | out_free;

        case (state)
            S_IDLE: begin
                if (c_code != C_SOP) begin
                    c_drdy = 1'b1;
                end else if (c_srdy && out_free) begin
                    acc_n[7:0] = c_data;
                    lane_n     = LSZ'(1);
                    len_n      = LEN_SZ'(1);
                    first_n    = 1'b1;
                    state_n    = S_PKT;
                end
            end

            S_PKT: begin
                if (c_srdy && c_code == C_SOP) begin
                    // SOP is left pending; it is taken in S_IDLE once the truncated word is out.
                    c_drdy = 1'b0;
                    if (out_free) begin
                        load     = 1'b1;
                        ld_data  = acc;
                        ld_cnt   = (lane == '0) ? '0 : lane - LSZ'(1);
                        ld_abort = 1'b1;
                        lane_n   = '0;
                        state_n  = S_IDLE;
                    end
                end else if (c_srdy && out_free) begin
                    acc_n = merged;
                    len_n = len_inc;
                    if (c_code == C_DATA) begin
                        if (len_inc == GIANT_LEN) begin
                            load     = 1'b1;
                            ld_abort = 1'b1;
                            ld_giant = 1'b1;
                            lane_n   = '0;
                            state_n  = S_DRAIN;
                        end else if (lane == LANE_LAST) begin
                            load    = 1'b1;
                            ld_code = first ? W_FIRST : W_MID;
                            first_n = 1'b0;
                            lane_n  = '0;
                        end else begin
                            lane_n = lane + LSZ'(1);
                        end
                    end else begin
                        load    = 1'b1;
                        ld_code = first ? W_SINGLE : W_LAST;
                        lane_n  = '0;
                        state_n = S_IDLE;
                        if (c_code == C_EOP_BAD) begin
                            ld_abort = 1'b1;
                            ld_crc   = 1'b1;
                        end else if (len_inc == GIANT_LEN) begin
                            ld_abort = 1'b1;
                            ld_giant = 1'b1;
                        end else if (len_inc < MIN_L) begin
                            ld_abort = 1'b1;
                            ld_runt  = 1'b1;
                        end else begin
                            ld_commit = 1'b1;
                            ld_len    = 1'b1;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (c_srdy) begin
                    case (c_code)
                        C_SOP: begin
                            acc_n[7:0] = c_data;
                            lane_n     = LSZ'(1);
                            len_n      = LEN_SZ'(1);
                            first_n    = 1'b1;
                            state_n    = S_PKT;
                        end
                        C_DATA:  len_n   = len_inc;
                        default: state_n = S_IDLE;
                    endcase
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            lane       <= '0;
            len        <= '0;
            first      <= 1'b0;
            acc        <= '0;
            p_srdy     <= 1'b0;
            p_code     <= '0;
            p_cnt      <= '0;
            p_data     <= '0;
            p_commit   <= 1'b0;
            p_abort    <= 1'b0;
            pkt_len    <= '0;
            drop_runt  <= 1'b0;
            drop_giant <= 1'b0;
            drop_crc   <= 1'b0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            len   <= len_n;
            first <= first_n;
            acc   <= acc_n;
            if (load) begin
                p_srdy   <= 1'b1;
                p_code   <= ld_code;
                p_cnt    <= ld_cnt;
                p_data   <= ld_data;
                p_commit <= ld_commit;
                p_abort  <= ld_abort;
            end else if (p_drdy) begin
                p_srdy   <= 1'b0;
                p_commit <= 1'b0;
                p_abort  <= 1'b0;
            end
            drop_runt  <= ld_runt;
            drop_giant <= ld_giant;
            drop_crc   <= ld_crc;
            if (ld_len) pkt_len <= len_n;
        end
    end

endmodule

// File: tb/tb_pkt_concentrator_n.sv
// Self-checking bench for pkt_concentrator_n: hand-derived frame table, truncation and reset
// sequences, then random back-to-back frames against a chunking reference model.
module tb_pkt_concentrator_n;

    localparam int LANES   = 8;
    localparam int LSZ     = 3;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int LEN_SZ  = 14;

    localparam int K_GOOD  = 0;
    localparam int K_BAD   = 1;
    localparam int K_TRUNC = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               c_srdy = 1'b0;
    logic               c_drdy;
    logic [1:0]         c_code = 2'b00;
    logic [7:0]         c_data = 8'h00;
    logic               p_srdy;
    logic               p_drdy = 1'b1;
    logic [1:0]         p_code;
    logic [LSZ-1:0]     p_cnt;
    logic [LANES*8-1:0] p_data;
    logic               p_commit, p_abort;
    logic [LEN_SZ-1:0]  pkt_len;
    logic               drop_runt, drop_giant, drop_crc;

    pkt_concentrator_n #(
        .LANES(LANES), .LSZ(LSZ), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_SZ(LEN_SZ)
    ) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_code(c_code), .c_data(c_data),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_code(p_code), .p_cnt(p_cnt), .p_data(p_data),
        .p_commit(p_commit), .p_abort(p_abort), .pkt_len(pkt_len),
        .drop_runt(drop_runt), .drop_giant(drop_giant), .drop_crc(drop_crc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]         code;
        int                 cnt;
        logic [LANES*8-1:0] data;
        int                 nchk;
        logic               commit;
        logic               abort;
    } word_t;

    typedef struct {
        int         len;
        int         kind;
        int         nw;
        logic [1:0] lcode;
        int         lcnt;
        logic       lcommit;
        logic       labort;
        int         plen;
        int         runt;
        int         giant;
        int         crc;
    } vec_t;

    word_t             exp_q[$];
    logic [7:0]        fb[$];
    int                errors = 0, checks = 0;
    int                n_runt = 0, n_giant = 0, n_crc = 0;
    int                e_runt = 0, e_giant = 0, e_crc = 0;
    logic [LEN_SZ-1:0] e_pkt_len = '0;
    int                nwords = 0;
    logic [1:0]        last_code = 2'b00;
    int                last_cnt = 0;
    logic              last_commit = 1'b0, last_abort = 1'b0;
    bit                ignore_out = 1'b0, rand_drdy = 1'b0;
    int                gap_pct = 0;
    int                sop_cyc = 0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(negedge clk);
        p_drdy = rand_drdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: sampled mid low-phase, once per cycle.
    initial begin : mon
        word_t              w;
        bit                 ok;
        bit                 hold;
        logic [1:0]         h_code;
        logic [LSZ-1:0]     h_cnt;
        logic [LANES*8-1:0] h_data;
        logic               h_commit, h_abort;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                hold = 1'b0;
                continue;
            end
            if (drop_runt)  n_runt++;
            if (drop_giant) n_giant++;
            if (drop_crc)   n_crc++;
            if (hold) begin
                checks++;
                if (!(p_srdy && p_code == h_code && p_cnt == h_cnt && p_data == h_data &&
                      p_commit == h_commit && p_abort == h_abort)) begin
                    errors++;
                    $display("FAIL hold_stable: got srdy=%0d code=%0d cnt=%0d commit=%0d abort=%0d, required srdy=1 code=%0d cnt=%0d commit=%0d abort=%0d",
                             p_srdy, p_code, p_cnt, p_commit, p_abort, h_code, h_cnt, h_commit, h_abort);
                end
            end
            if (p_srdy && p_drdy && !ignore_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got code=%0d cnt=%0d abort=%0d, required no word", p_code, p_cnt, p_abort);
                end else begin
                    w  = exp_q.pop_front();
                    ok = (p_code == w.code) && (p_cnt == LSZ'(w.cnt)) &&
                         (p_commit == w.commit) && (p_abort == w.abort);
                    for (int i = 0; i < w.nchk; i++)
                        if (p_data[8*i +: 8] != w.data[8*i +: 8]) ok = 1'b0;
                    if (!ok) begin
                        errors++;
                        $display("FAIL word: got code=%0d cnt=%0d commit=%0d abort=%0d data=%h, required code=%0d cnt=%0d commit=%0d abort=%0d data=%h (low %0d bytes)",
                                 p_code, p_cnt, p_commit, p_abort, p_data, w.code, w.cnt, w.commit, w.abort, w.data, w.nchk);
                    end
                end
                nwords++;
                last_code   = p_code;
                last_cnt    = int'(p_cnt);
                last_commit = p_commit;
                last_abort  = p_abort;
            end
            hold     = p_srdy && !p_drdy;
            h_code   = p_code;
            h_cnt    = p_cnt;
            h_data   = p_data;
            h_commit = p_commit;
            h_abort  = p_abort;
        end
    end

    // Reference model: chop the frame into LANES-byte chunks and decide the final word's fate.
    task automatic model_frame(input int n, input int kind);
        int    eff, chunk;
        bit    giant;
        word_t w;
        eff   = n;
        giant = 1'b0;
        if (kind != K_TRUNC && n > MAX_LEN) begin
            eff   = MAX_LEN + 1;
            giant = 1'b1;
        end
        for (int s = 0; s < eff; s += LANES) begin
            chunk    = (eff - s < LANES) ? eff - s : LANES;
            w.data   = '0;
            for (int i = 0; i < chunk; i++) w.data[8*i +: 8] = fb[s+i];
            w.nchk   = chunk;
            w.cnt    = chunk - 1;
            w.commit = 1'b0;
            w.abort  = 1'b0;
            if (s + LANES < eff || (kind == K_TRUNC && chunk == LANES)) begin
                w.code = (s == 0) ? 2'b00 : 2'b01;
            end else begin
                w.code = (s == 0 && !giant && kind != K_TRUNC) ? 2'b11 : 2'b10;
                if (giant) begin
                    w.abort = 1'b1; e_giant++;
                end else if (kind == K_TRUNC) begin
                    w.abort = 1'b1;
                end else if (kind == K_BAD) begin
                    w.abort = 1'b1; e_crc++;
                end else if (n < MIN_LEN) begin
                    w.abort = 1'b1; e_runt++;
                end else begin
                    w.commit  = 1'b1;
                    e_pkt_len = LEN_SZ'(n);
                end
            end
            exp_q.push_back(w);
        end
        if (kind == K_TRUNC && eff % LANES == 0) begin
            w.code = 2'b10; w.cnt = 0; w.nchk = 0; w.data = '0;
            w.commit = 1'b0; w.abort = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        c_srdy = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic put_byte(input logic [1:0] code, input logic [7:0] data, output int cyc);
        bit done;
        done   = 1'b0;
        cyc    = 0;
        c_srdy = 1'b1;
        c_code = code;
        c_data = data;
        while (!done && cyc < 1000) begin
            #1;
            done = c_drdy;
            @(negedge clk);
            cyc++;
        end
        c_srdy = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte code=%0d not accepted within %0d cycles, required acceptance", code, cyc);
        end
    endtask

    task automatic send_frame(input int n, input int kind);
        logic [1:0] code;
        int         cyc;
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
        model_frame(n, kind);
        for (int i = 0; i < n; i++) begin
            if (i == 0)                             code = 2'b00;
            else if (i == n - 1 && kind != K_TRUNC) code = (kind == K_BAD) ? 2'b11 : 2'b10;
            else                                    code = 2'b01;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1 + $urandom_range(0, 2));
            put_byte(code, fb[i], cyc);
            if (i == 0) sop_cyc = cyc;
        end
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d words still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (n_runt != e_runt || n_giant != e_giant || n_crc != e_crc) begin
            errors++;
            $display("FAIL %s pulses: got runt=%0d giant=%0d crc=%0d, required runt=%0d giant=%0d crc=%0d",
                     name, n_runt, n_giant, n_crc, e_runt, e_giant, e_crc);
        end
        checks++;
        if (pkt_len !== e_pkt_len) begin
            errors++;
            $display("FAIL %s pkt_len: got %0d, required %0d", name, pkt_len, e_pkt_len);
        end
    endtask

    task automatic trunc_case(input int k, input string name);
        int nw0;
        nw0 = nwords;
        send_frame(k, K_TRUNC);
        send_frame(MIN_LEN, K_GOOD);
        checks++;
        if (sop_cyc != 2) begin
            errors++;
            $display("FAIL %s sop_stall: SOP took %0d cycles, required 2", name, sop_cyc);
        end
        wait_drain(name);
        checks++;
        if (nwords - nw0 != (k / LANES) + 1 + MIN_LEN / LANES) begin
            errors++;
            $display("FAIL %s word_count: got %0d, required %0d", name, nwords - nw0, (k / LANES) + 1 + MIN_LEN / LANES);
        end
    endtask

    vec_t tbl[10];

    initial begin
        int cyc, nw0, r0, g0, k0, sel, n, kind;

        tbl[0] = '{64,   K_GOOD, 8,   2'b10, 7, 1'b1, 1'b0, 64,   0, 0, 0};
        tbl[1] = '{65,   K_GOOD, 9,   2'b10, 0, 1'b1, 1'b0, 65,   0, 0, 0};
        tbl[2] = '{40,   K_GOOD, 5,   2'b10, 7, 1'b0, 1'b1, 65,   1, 0, 0};
        tbl[3] = '{64,   K_BAD,  8,   2'b10, 7, 1'b0, 1'b1, 65,   0, 0, 1};
        tbl[4] = '{1600, K_GOOD, 190, 2'b10, 6, 1'b0, 1'b1, 65,   0, 1, 0};
        tbl[5] = '{1518, K_GOOD, 190, 2'b10, 5, 1'b1, 1'b0, 1518, 0, 0, 0};
        tbl[6] = '{5,    K_GOOD, 1,   2'b11, 4, 1'b0, 1'b1, 1518, 1, 0, 0};
        tbl[7] = '{8,    K_BAD,  1,   2'b11, 7, 1'b0, 1'b1, 1518, 0, 0, 1};
        tbl[8] = '{63,   K_GOOD, 8,   2'b10, 6, 1'b0, 1'b1, 1518, 1, 0, 0};
        tbl[9] = '{1520, K_BAD,  190, 2'b10, 6, 1'b0, 1'b1, 1518, 0, 1, 0};

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (c_drdy !== 1'b1 || p_srdy !== 1'b0 || p_commit !== 1'b0 || p_abort !== 1'b0 ||
            pkt_len !== '0 || drop_runt !== 1'b0 || drop_giant !== 1'b0 || drop_crc !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got c_drdy=%0d p_srdy=%0d commit=%0d abort=%0d pkt_len=%0d drops=%0d%0d%0d, required 1 0 0 0 0 000",
                     c_drdy, p_srdy, p_commit, p_abort, pkt_len, drop_runt, drop_giant, drop_crc);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Non-SOP bytes in IDLE are swallowed in one cycle and produce nothing.
        put_byte(2'b01, 8'hA5, cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL idle_data: took %0d cycles, required 1", cyc); end
        put_byte(2'b10, 8'h5A, cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL idle_eop: took %0d cycles, required 1", cyc); end
        put_byte(2'b11, 8'h3C, cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL idle_eop_bad: took %0d cycles, required 1", cyc); end

        for (int r = 0; r < 10; r++) begin
            nw0 = nwords; r0 = n_runt; g0 = n_giant; k0 = n_crc;
            send_frame(tbl[r].len, tbl[r].kind);
            wait_drain($sformatf("row%0d", r));
            checks++;
            if (nwords - nw0 != tbl[r].nw) begin
                errors++;
                $display("FAIL row%0d word_count: got %0d, required %0d", r, nwords - nw0, tbl[r].nw);
            end
            checks++;
            if (last_code !== tbl[r].lcode || last_cnt != tbl[r].lcnt ||
                last_commit !== tbl[r].lcommit || last_abort !== tbl[r].labort) begin
                errors++;
                $display("FAIL row%0d last_word: got code=%0d cnt=%0d commit=%0d abort=%0d, required code=%0d cnt=%0d commit=%0d abort=%0d",
                         r, last_code, last_cnt, last_commit, last_abort,
                         tbl[r].lcode, tbl[r].lcnt, tbl[r].lcommit, tbl[r].labort);
            end
            checks++;
            if (pkt_len !== LEN_SZ'(tbl[r].plen)) begin
                errors++;
                $display("FAIL row%0d pkt_len_const: got %0d, required %0d", r, pkt_len, tbl[r].plen);
            end
            checks++;
            if (n_runt - r0 != tbl[r].runt || n_giant - g0 != tbl[r].giant || n_crc - k0 != tbl[r].crc) begin
                errors++;
                $display("FAIL row%0d pulse_count: got runt=%0d giant=%0d crc=%0d, required %0d %0d %0d",
                         r, n_runt - r0, n_giant - g0, n_crc - k0, tbl[r].runt, tbl[r].giant, tbl[r].crc);
            end
        end

        // SOP interrupting a packet at a partial lane, at a word boundary, and inside the first word.
        trunc_case(10, "trunc10");
        trunc_case(16, "trunc16");
        trunc_case(3,  "trunc3");

        // Reset in the middle of a packet discards it; the next frame starts clean.
        ignore_out = 1'b1;
        for (int i = 0; i < 20; i++) put_byte((i == 0) ? 2'b00 : 2'b01, 8'(i), cyc);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (p_srdy !== 1'b0 || c_drdy !== 1'b1 || pkt_len !== '0) begin
            errors++;
            $display("FAIL mid_reset: got p_srdy=%0d c_drdy=%0d pkt_len=%0d, required 0 1 0", p_srdy, c_drdy, pkt_len);
        end
        @(negedge clk);
        reset = 1'b0;
        e_pkt_len = '0;
        @(negedge clk);
        ignore_out = 1'b0;
        nw0 = nwords;
        send_frame(MIN_LEN, K_GOOD);
        wait_drain("after_reset");
        checks++;
        if (nwords - nw0 != 8) begin
            errors++;
            $display("FAIL after_reset word_count: got %0d, required 8", nwords - nw0);
        end

        // Back-to-back random frames with 50% output backpressure and input gaps.
        rand_drdy = 1'b1;
        gap_pct   = 20;
        for (int f = 0; f < 14; f++) begin
            sel = $urandom_range(0, 99);
            if (f == 13 || sel < 65) begin
                kind = K_GOOD; n = $urandom_range(MIN_LEN, MAX_LEN);
            end else if (sel < 80) begin
                kind = K_BAD;  n = $urandom_range(2, MAX_LEN);
            end else if (sel < 90) begin
                kind = K_GOOD; n = $urandom_range(2, MIN_LEN - 1);
            end else begin
                kind = K_TRUNC; n = $urandom_range(1, 300);
            end
            send_frame(n, kind);
        end
        wait_drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
